// File: rtl/iterative_multiplier.sv
// Shift-add multiplier: full 2N-bit signed/unsigned product, B multiplier bits per cycle, result N/B cycles after accept.
// Valid/ready on both sides; in_ready only in IDLE, and DONE holds result/out_valid until out_ready.
module iterative_multiplier #(
  parameter int N = 8,
  parameter int B = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in0,
  input  logic [N-1:0]   in1,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] result
);

  localparam int ITER = N / B;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_last;

  logic             r_neg;
  logic [2*N-1:0]   r_mcand;
  logic [N-1:0]     r_mplier;
  logic [2*N-1:0]   r_acc;
  logic [CW-1:0]    r_cnt;
  logic [2*N-1:0]   r_result;

  logic             w_neg;
  logic [N-1:0]     w_mag0;
  logic [N-1:0]     w_mag1;
  logic [2*N-1:0]   w_pp;
  logic [2*N-1:0]   w_sum;
  logic [2*N-1:0]   w_final;

  // Operands are reduced to magnitudes; the sign is reapplied once at the end.
  assign w_neg  = is_signed & (in0[N-1] ^ in1[N-1]);
  assign w_mag0 = (is_signed && in0[N-1]) ? (~in0 + N'(1)) : in0;
  assign w_mag1 = (is_signed && in1[N-1]) ? (~in1 + N'(1)) : in1;

  assign w_pp    = r_mcand * {{(2*N-B){1'b0}}, r_mplier[B-1:0]};
  assign w_sum   = r_acc + w_pp;
  assign w_final = r_neg ? (~w_sum + (2*N)'(1)) : w_sum;

  assign result = r_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    w_last    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == CW'(ITER - 1)) begin
          w_last = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg    <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_neg    <= w_neg;
      r_mcand  <= {{N{1'b0}}, w_mag0};
      r_mplier <= w_mag1;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_BUSY) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << B;
      r_mplier <= r_mplier >> B;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        r_result <= w_final;
      end
    end
  end

endmodule

// File: tb/tb_iterative_multiplier.sv
// Bench: directed checks on N=8 B=1 and B=4 side by side, then a random regression over every legal (N,B) for N in {4,8,16}.
module tb_iterative_multiplier;

  localparam int NCFG = 12;

  int tests = 0;
  int fails = 0;

  logic clk;
  logic rst_n_d;
  logic rst_n_r;

  logic        in_valid;
  logic [7:0]  in0;
  logic [7:0]  in1;
  logic        is_signed;
  logic        out_ready;
  logic        d1_in_ready, d1_out_valid;
  logic        d4_in_ready, d4_out_valid;
  logic [15:0] d1_result, d4_result;

  logic        rv_in_valid  [NCFG];
  logic        rv_in_ready  [NCFG];
  logic        rv_signed    [NCFG];
  logic        rv_out_valid [NCFG];
  logic        rv_out_ready [NCFG];
  logic [15:0] rv_in0       [NCFG];
  logic [15:0] rv_in1       [NCFG];
  logic [31:0] rv_result    [NCFG];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cfg_n(input int i);
    if (i < 3) return 4;
    else if (i < 7) return 8;
    else return 16;
  endfunction

  function automatic int cfg_b(input int i);
    if (i < 3) return 1 << i;
    else if (i < 7) return 1 << (i - 3);
    else return 1 << (i - 7);
  endfunction

  iterative_multiplier #(.N(8), .B(1)) u_d1 (
    .clk(clk), .rst_n(rst_n_d), .in_valid(in_valid), .in_ready(d1_in_ready),
    .in0(in0), .in1(in1), .is_signed(is_signed), .out_valid(d1_out_valid),
    .out_ready(out_ready), .result(d1_result)
  );

  iterative_multiplier #(.N(8), .B(4)) u_d4 (
    .clk(clk), .rst_n(rst_n_d), .in_valid(in_valid), .in_ready(d4_in_ready),
    .in0(in0), .in1(in1), .is_signed(is_signed), .out_valid(d4_out_valid),
    .out_ready(out_ready), .result(d4_result)
  );

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_rnd
    localparam int NN = cfg_n(gi);
    localparam int BB = cfg_b(gi);
    logic [2*NN-1:0] w_res;
    iterative_multiplier #(.N(NN), .B(BB)) u_dut (
      .clk(clk), .rst_n(rst_n_r), .in_valid(rv_in_valid[gi]), .in_ready(rv_in_ready[gi]),
      .in0(rv_in0[gi][NN-1:0]), .in1(rv_in1[gi][NN-1:0]), .is_signed(rv_signed[gi]),
      .out_valid(rv_out_valid[gi]), .out_ready(rv_out_ready[gi]), .result(w_res)
    );
    assign rv_result[gi] = 32'(w_res);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: interpret operands as integers, multiply, keep the low 2N bits.
  function automatic logic [31:0] ref_prod(input int n, input logic [15:0] a, input logic [15:0] b,
                                           input logic s);
    longint ea, eb, p;
    ea = longint'(a);
    eb = longint'(b);
    if (s && a[n-1]) ea = ea - (longint'(1) << n);
    if (s && b[n-1]) eb = eb - (longint'(1) << n);
    p = ea * eb;
    return 32'(p & ((longint'(1) << (2 * n)) - 1));
  endfunction

  function automatic logic [15:0] pick(input int n);
    logic [15:0] m;
    int sel;
    m   = 16'((32'd1 << n) - 1);
    sel = $urandom_range(0, 7);
    case (sel)
      0: return 16'd0;
      1: return 16'(32'd1 << (n - 1));
      2: return m;
      default: return 16'($urandom) & m;
    endcase
  endfunction

  task automatic dir_txn(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [15:0] exp, input string tag);
    int k, k1, k4;
    logic rdy_seen;
    in0 = a; in1 = b; is_signed = s; in_valid = 1'b1;
    k = 0;
    while (!(d1_in_ready && d4_in_ready) && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk({tag, "_accept"}, 64'(d1_in_ready & d4_in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in0 = ~a; in1 = ~b; is_signed = ~s;
    k = 0; k1 = -1; k4 = -1; rdy_seen = 1'b0;
    while (k < 50) begin
      if (d1_out_valid && k1 < 0) k1 = k;
      if (d4_out_valid && k4 < 0) k4 = k;
      if (k1 >= 0 && k4 >= 0) break;
      if (d1_in_ready || d4_in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1; k++;
    end
    chk({tag, "_lat_b1"}, 64'(k1), 64'd8);
    chk({tag, "_lat_b4"}, 64'(k4), 64'd2);
    chk({tag, "_busy_rdy"}, 64'(rdy_seen), 64'd0);
    chk({tag, "_res_b1"}, 64'(d1_result), 64'(exp));
    chk({tag, "_res_b4"}, 64'(d4_result), 64'(exp));
  endtask

  task automatic dir_drain(input logic [15:0] exp, input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drain_rdy"}, 64'(d1_in_ready & d4_in_ready), 64'd1);
    chk({tag, "_drain_vld"}, 64'(d1_out_valid | d4_out_valid), 64'd0);
    chk({tag, "_drain_hold"}, 64'(d1_result), 64'(exp));
  endtask

  task automatic rnd_txn(input int i);
    int n, it, k;
    logic [15:0] a, b;
    logic s;
    logic [31:0] exp;
    n  = cfg_n(i);
    it = n / cfg_b(i);
    a = pick(n); b = pick(n); s = 1'($urandom_range(0, 1));
    exp = ref_prod(n, a, b, s);
    repeat ($urandom_range(0, 3)) begin
      rv_in0[i] = 16'($urandom); rv_in_valid[i] = 1'b0;
      @(posedge clk); #1;
    end
    rv_in0[i] = a; rv_in1[i] = b; rv_signed[i] = s; rv_in_valid[i] = 1'b1;
    k = 0;
    while (!rv_in_ready[i] && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("rnd_accept", 64'(rv_in_ready[i]), 64'd1);
    @(posedge clk); #1;
    rv_in_valid[i] = 1'b0;
    rv_in0[i] = 16'($urandom); rv_in1[i] = 16'($urandom); rv_signed[i] = ~s;
    k = 0;
    while (!rv_out_valid[i] && k < 50) begin
      rv_out_ready[i] = 1'($urandom_range(0, 1));
      @(posedge clk); #1; k++;
    end
    chk("rnd_lat", 64'(k), 64'(it));
    rv_out_ready[i] = 1'b0;
    repeat ($urandom_range(0, 3)) begin
      @(posedge clk); #1;
    end
    chk("rnd_res", 64'(rv_result[i]), 64'(exp));
    rv_out_ready[i] = 1'b1;
    @(posedge clk); #1;
    rv_out_ready[i] = 1'b0;
  endtask

  initial begin
    in_valid = 1'b0; in0 = '0; in1 = '0; is_signed = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < NCFG; i++) begin
      rv_in_valid[i] = 1'b0; rv_signed[i] = 1'b0; rv_out_ready[i] = 1'b0;
      rv_in0[i] = '0; rv_in1[i] = '0;
    end
    rst_n_d = 1'b1; rst_n_r = 1'b1;
    #1;
    rst_n_d = 1'b0; rst_n_r = 1'b0;
    #1;
    chk("rst_in_ready", 64'(d1_in_ready & d4_in_ready), 64'd1);
    chk("rst_out_valid", 64'(d1_out_valid | d4_out_valid), 64'd0);
    chk("rst_result", 64'(d1_result), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n_d = 1'b1; rst_n_r = 1'b1;
    @(posedge clk); #1;

    dir_txn(8'd13, 8'd11, 1'b0, 16'h008F, "u13x11");
    dir_drain(16'h008F, "u13x11");
    dir_txn(8'hFD, 8'h05, 1'b1, 16'hFFF1, "sm3x5");
    dir_drain(16'hFFF1, "sm3x5");
    dir_txn(8'h80, 8'h80, 1'b1, 16'h4000, "s80x80");
    dir_drain(16'h4000, "s80x80");
    dir_txn(8'hFF, 8'hFF, 1'b0, 16'hFE01, "uffxff");
    dir_drain(16'hFE01, "uffxff");
    dir_txn(8'h80, 8'h7F, 1'b1, 16'hC080, "s80x7f");
    dir_drain(16'hC080, "s80x7f");

    // Backpressure: stay in DONE while the input side is thrashed.
    dir_txn(8'h12, 8'h34, 1'b0, 16'h03A8, "bp");
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in0 = 8'($urandom); in1 = 8'($urandom); is_signed = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("bp_result", 64'(d1_result), 64'h03A8);
      chk("bp_out_valid", 64'(d1_out_valid & d4_out_valid), 64'd1);
      chk("bp_in_ready", 64'(d1_in_ready | d4_in_ready), 64'd0);
    end
    in_valid = 1'b0;
    dir_drain(16'h03A8, "bp");

    // Reset lands between clock edges at BUSY step 3 of the B=1 unit.
    in0 = 8'h55; in1 = 8'h66; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("pre_rst_b4_vld", 64'(d4_out_valid), 64'd1);
    rst_n_d = 1'b0;
    #1;
    chk("mid_rst_vld", 64'(d1_out_valid | d4_out_valid), 64'd0);
    chk("mid_rst_res_b1", 64'(d1_result), 64'd0);
    chk("mid_rst_res_b4", 64'(d4_result), 64'd0);
    chk("mid_rst_rdy", 64'(d1_in_ready & d4_in_ready), 64'd1);
    #1;
    rst_n_d = 1'b1;
    @(posedge clk); #1;
    dir_txn(8'd7, 8'd9, 1'b0, 16'h003F, "u7x9");
    dir_drain(16'h003F, "u7x9");

    for (int i = 0; i < NCFG; i++) begin
      for (int t = 0; t < 15; t++) begin
        rnd_txn(i);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
